wb_grf: RTL and testbench
=========================

Name: wb_grf

Overview:
- Write-back stage plus general register file: the write end of the GRF read interface used by the decode stage.
- Holds the MEM/WB pipeline register and a 32x32 register file with two combinational read ports.
- Forwards the write-back result internally, so decode needs forwarding only from EX and MEM.
- Single clock domain; sits between the MEM stage and the decode stage's RA1_GRF/RA2_GRF/RD1_GRF/RD2_GRF interface.

Parameters:
- GP_INIT, 32'h0000_1800, reset value of register $28.
- SP_INIT, 32'h0000_2ffc, reset value of register $29.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hold MEM/WB register
- clr  input  1  load a bubble into MEM/WB register
- PC_MEM  input  32  PC of instruction leaving MEM
- regaddr_MEM  input  5  destination register from MEM (0 = no write)
- regdata_MEM  input  32  write data from MEM
- RA1_GRF  input  5  read address, port 1 (rs)
- RA2_GRF  input  5  read address, port 2 (rt)
- RD1_GRF  output  32  read data, port 1
- RD2_GRF  output  32  read data, port 2
- PC_WB  output  32  registered PC in WB
- regaddr_WB  output  5  registered destination in WB
- regdata_WB  output  32  registered write data in WB
- wcount  output  32  count of committed register writes

Behaviour:
- Reset (async, asserted):
  - PC_WB, regaddr_WB, regdata_WB and wcount go to 0 immediately.
  - All registers go to 0, except $28 = GP_INIT and $29 = SP_INIT.
  - Reset mid-operation discards the pending WB write; no write happens on the edge where reset is high.
- MEM/WB register, on each rising edge, priority reset > clr > stall:
  - clr: all three WB outputs load 0 (bubble).
  - stall (and no clr): hold current values.
  - otherwise: load PC_MEM, regaddr_MEM, regdata_MEM.
- Register write, on each rising edge when not in reset:
  - If regaddr_WB != 0, then reg[regaddr_WB] <= regdata_WB and wcount <= wcount + 1.
  - The write is independent of stall and clr. A held WB entry rewrites the same value, and wcount counts it again; this is intentional.
  - Writes to $0 are ignored, $0 reads as 0 always, and wcount does not increment for them.
- Read ports, combinational, evaluated independently per port:
  - RA == 0 -> 0.
  - else RA == regaddr_WB -> regdata_WB (inner forward, same-cycle visibility).
  - else reg[RA].
  - Both ports may hit the same address or the forward path simultaneously.
- Latency:
  - MEM -> WB register is 1 cycle.
  - WB -> visible on RD1/RD2 in the same cycle via forward; committed to the array at the end of that cycle.
- wcount is 32-bit and wraps from 32'hFFFF_FFFF to 0.
- No registered read outputs; RD1/RD2 have no reset value beyond the array contents.

Optional Feature:
- Macro: GRF_WRITE_TRACE_EN.
- Defined: on every committed write (regaddr_WB != 0, not in reset), the simulator prints "@%h: $%d <= %h" with PC_WB, regaddr_WB and regdata_WB, using a two-digit decimal register number and 8-digit hex values. No output for $0 writes or bubbles.
- Undefined: no trace statements are compiled; behaviour is otherwise identical.

Test Plan:
- Reset check: assert reset mid-cycle -> all WB outputs 0 and wcount 0 immediately; RA1=28 gives 32'h0000_1800, RA2=29 gives 32'h0000_2ffc, RA1=5 gives 0.
- Basic write and forward: MEM sends (PC 0x3000, addr 8, data 0x1234), then the next cycle RA1=8 -> RD1 = 0x1234 in the WB cycle via forward. After the following edge, with a bubble in WB, RD1 still reads 0x1234. wcount = 1.
- $0 protection: MEM sends (addr 0, data 0xFFFF_FFFF) -> RA1=0 reads 0 in the WB cycle and after; wcount unchanged.
- Stall and clr:
  - With WB holding addr 9 / data 0xAA, assert stall for 3 cycles -> WB outputs hold, reg9 = 0xAA, wcount += 3.
  - Assert clr together with stall -> WB outputs become 0.
- Dual-port hazard: WB holds addr 17 / data 0x55, reg17 previously 0x11, RA1=RA2=17 -> both ports read 0x55 the same cycle. With RA2=16 -> RD2 shows the array value.
- Trace on (GRF_WRITE_TRACE_EN defined): the write from the basic-write scenario prints "@00003000: $ 8 <= 00001234" exactly once; the bubble cycles print nothing.

Source files
------------

// File: rtl/wb_grf.sv
// Write-back stage: MEM/WB pipeline register plus 32x32 register file with inner forwarding.
// Optional write trace is compiled in when GRF_WRITE_TRACE_EN is defined.
module wb_grf #(
    parameter logic [31:0] GP_INIT = 32'h0000_1800,
    parameter logic [31:0] SP_INIT = 32'h0000_2ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        clr,
    input  logic [31:0] PC_MEM,
    input  logic [4:0]  regaddr_MEM,
    input  logic [31:0] regdata_MEM,
    input  logic [4:0]  RA1_GRF,
    input  logic [4:0]  RA2_GRF,
    output logic [31:0] RD1_GRF,
    output logic [31:0] RD2_GRF,
    output logic [31:0] PC_WB,
    output logic [4:0]  regaddr_WB,
    output logic [31:0] regdata_WB,
    output logic [31:0] wcount
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC_WB      <= '0;
            regaddr_WB <= '0;
            regdata_WB <= '0;
        end else if (clr) begin
            PC_WB      <= '0;
            regaddr_WB <= '0;
            regdata_WB <= '0;
        end else if (!stall) begin
            PC_WB      <= PC_MEM;
            regaddr_WB <= regaddr_MEM;
            regdata_WB <= regdata_MEM;
        end
    end

    // The commit ignores stall/clr: a held WB entry is rewritten and counted every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                if (i == 28)
                    regs[i[4:0]] <= GP_INIT;
                else if (i == 29)
                    regs[i[4:0]] <= SP_INIT;
                else
                    regs[i[4:0]] <= '0;
            end
            wcount <= '0;
        end else if (regaddr_WB != '0) begin
            regs[regaddr_WB] <= regdata_WB;
            wcount           <= wcount + 32'd1;
`ifdef GRF_WRITE_TRACE_EN
            $display("@%h: $%d <= %h", PC_WB, regaddr_WB, regdata_WB);
`endif
        end
    end

    always_comb begin
        RD1_GRF = regs[RA1_GRF];
        if (RA1_GRF == '0)
            RD1_GRF = '0;
        else if (RA1_GRF == regaddr_WB)
            RD1_GRF = regdata_WB;
    end

    always_comb begin
        RD2_GRF = regs[RA2_GRF];
        if (RA2_GRF == '0)
            RD2_GRF = '0;
        else if (RA2_GRF == regaddr_WB)
            RD2_GRF = regdata_WB;
    end

endmodule

// File: tb/tb_wb_grf.sv
// Bench for wb_grf: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against an array-based model of the write-back stage.
module tb_wb_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        clr;
    logic [31:0] PC_MEM;
    logic [4:0]  regaddr_MEM;
    logic [31:0] regdata_MEM;
    logic [4:0]  RA1_GRF;
    logic [4:0]  RA2_GRF;
    logic [31:0] RD1_GRF;
    logic [31:0] RD2_GRF;
    logic [31:0] PC_WB;
    logic [4:0]  regaddr_WB;
    logic [31:0] regdata_WB;
    logic [31:0] wcount;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // model state
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_wc;

    wb_grf #(.GP_INIT(32'h0000_1800), .SP_INIT(32'h0000_2ffc)) dut (
        .clk(clk), .reset(reset), .stall(stall), .clr(clr),
        .PC_MEM(PC_MEM), .regaddr_MEM(regaddr_MEM), .regdata_MEM(regdata_MEM),
        .RA1_GRF(RA1_GRF), .RA2_GRF(RA2_GRF), .RD1_GRF(RD1_GRF), .RD2_GRF(RD2_GRF),
        .PC_WB(PC_WB), .regaddr_WB(regaddr_WB), .regdata_WB(regdata_WB), .wcount(wcount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] ra);
        if (ra == 5'd0) return 32'd0;
        if (ra == m_addr) return m_data;
        return m_regs[ra];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_regs[28] = 32'h0000_1800;
        m_regs[29] = 32'h0000_2ffc;
        m_pc = 32'd0; m_addr = 5'd0; m_data = 32'd0; m_wc = 32'd0;
    endtask

    // What one rising edge does, given the inputs present at that edge.
    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else begin
            if (m_addr != 5'd0) begin
                m_regs[m_addr] = m_data;
                m_wc = m_wc + 32'd1;
            end
            if (clr) begin
                m_pc = 32'd0; m_addr = 5'd0; m_data = 32'd0;
            end else if (!stall) begin
                m_pc = PC_MEM; m_addr = regaddr_MEM; m_data = regdata_MEM;
            end
        end
    endtask

    task automatic check_all();
        chk("PC_WB", PC_WB, m_pc);
        chk("regaddr_WB", {27'd0, regaddr_WB}, {27'd0, m_addr});
        chk("regdata_WB", regdata_WB, m_data);
        chk("wcount", wcount, m_wc);
        chk("RD1", RD1_GRF, m_read(RA1_GRF));
        chk("RD2", RD2_GRF, m_read(RA2_GRF));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic mem(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
        PC_MEM = pc; regaddr_MEM = a; regdata_MEM = d;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; clr = 1'b0;
        mem(32'd0, 5'd0, 32'd0);
        RA1_GRF = 5'd0; RA2_GRF = 5'd0;
        model_reset();
        tick(); tick();

        // pending write discarded by a mid-cycle reset
        reset = 1'b0;
        mem(32'h100, 5'd3, 32'h5);
        settle();
        tick();
        RA1_GRF = 5'd3;
        settle();
        chk("pre_reset_fwd", RD1_GRF, 32'h5);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rst_pc", PC_WB, 32'd0);
        chk("rst_addr", {27'd0, regaddr_WB}, 32'd0);
        chk("rst_data", regdata_WB, 32'd0);
        chk("rst_wcount", wcount, 32'd0);
        RA1_GRF = 5'd28; RA2_GRF = 5'd29;
        settle();
        chk("rst_gp", RD1_GRF, 32'h0000_1800);
        chk("rst_sp", RD2_GRF, 32'h0000_2ffc);
        RA1_GRF = 5'd5;
        settle();
        chk("rst_r5", RD1_GRF, 32'd0);
        tick();
        reset = 1'b0;
        RA1_GRF = 5'd3;
        mem(32'd0, 5'd0, 32'd0);
        settle();
        chk("discarded_r3", RD1_GRF, 32'd0);

        // basic write with forward, then read from the array behind a bubble
        mem(32'h3000, 5'd8, 32'h1234);
        settle();
        tick();
        RA1_GRF = 5'd8;
        mem(32'd0, 5'd0, 32'd0);
        settle();
        chk("fwd_r8", RD1_GRF, 32'h1234);
        chk("wb_pc", PC_WB, 32'h3000);
        tick();
        settle();
        chk("array_r8", RD1_GRF, 32'h1234);
        chk("wcount_1", wcount, 32'd1);

        // $0 protection
        mem(32'h3004, 5'd0, 32'hFFFF_FFFF);
        settle();
        tick();
        RA1_GRF = 5'd0;
        settle();
        chk("r0_wb", RD1_GRF, 32'd0);
        mem(32'd0, 5'd0, 32'd0);
        tick();
        settle();
        chk("r0_after", RD1_GRF, 32'd0);
        chk("wcount_r0", wcount, 32'd1);

        // stall holds WB and recounts its write; clr with stall bubbles
        mem(32'h3008, 5'd9, 32'hAA);
        settle();
        tick();
        stall = 1'b1;
        mem(32'h3010, 5'd10, 32'hBB);
        RA1_GRF = 5'd9;
        settle();
        repeat (3) begin
            tick();
            settle();
        end
        chk("stall_addr", {27'd0, regaddr_WB}, 32'd9);
        chk("stall_data", regdata_WB, 32'hAA);
        chk("stall_wcount", wcount, 32'd4);
        chk("stall_r9", RD1_GRF, 32'hAA);
        clr = 1'b1;
        settle();
        tick();
        settle();
        chk("clr_addr", {27'd0, regaddr_WB}, 32'd0);
        chk("clr_data", regdata_WB, 32'd0);
        chk("clr_pc", PC_WB, 32'd0);
        chk("clr_wcount", wcount, 32'd5);
        chk("clr_r9", RD1_GRF, 32'hAA);
        clr = 1'b0; stall = 1'b0;

        // dual-port hazard on the forward path
        mem(32'h3020, 5'd17, 32'h11);
        settle();
        tick();
        mem(32'h3024, 5'd17, 32'h55);
        settle();
        tick();
        mem(32'd0, 5'd0, 32'd0);
        RA1_GRF = 5'd17; RA2_GRF = 5'd17;
        settle();
        chk("dual_rd1", RD1_GRF, 32'h55);
        chk("dual_rd2", RD2_GRF, 32'h55);
        RA2_GRF = 5'd16;
        settle();
        chk("dual_r16", RD2_GRF, 32'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            if ($urandom_range(99) == 0) begin
                reset = 1'b1;
                model_reset();
            end else begin
                reset = 1'b0;
            end
            stall = ($urandom_range(99) < 20);
            clr   = ($urandom_range(99) < 10);
            mem($urandom, 5'($urandom_range(31)), $urandom);
            RA1_GRF = ($urandom_range(3) == 0) ? m_addr : 5'($urandom_range(31));
            RA2_GRF = ($urandom_range(3) == 0) ? m_addr : 5'($urandom_range(31));
            settle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
